// File: rtl/axis_tlp_seq_tagger.sv
// Stamps each outgoing TLP with a 12-bit data-link sequence number in a prepended header beat,
// tracks NEXT_TRANSMIT_SEQ / ACKD_SEQ, stalls new frames at 2048 outstanding and truncates oversize frames.
module axis_tlp_seq_tagger #(
    parameter int DATA_WIDTH       = 32,
    parameter int KEEP_WIDTH       = DATA_WIDTH / 8,
    parameter int USER_WIDTH       = 1,
    parameter int MAX_PAYLOAD_SIZE = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready,
    input  logic                  ack_valid_i,
    input  logic [11:0]           ack_seq_i,
    output logic [11:0]           next_seq_o,
    output logic [11:0]           ackd_seq_o,
    output logic                  blocked_o,
    output logic                  trunc_o,
    output logic [1:0]            fsm_state
);

    // Handshake: a beat transfers on a rising edge where valid && ready; valid never depends on ready,
    // and a presented output beat stays unchanged until it transfers.

    localparam int MAX_PKT_BEATS = (MAX_PAYLOAD_SIZE >> 2) + 4;
    localparam int CNT_W         = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_next;
    logic [11:0]       next_seq, ackd_seq;
    logic [11:0]       outstanding, d_new, d_old;
    logic              slot_free, load_hdr, load_beat, force_trunc, seq_inc;
    logic [USER_WIDTH-1:0] beat_user;

    assign slot_free   = !m_axis_tvalid || m_axis_tready;
    assign outstanding = next_seq - ackd_seq - 12'd1;
    assign blocked_o   = (outstanding >= 12'd2048);
    assign d_new       = next_seq - 12'd1 - ack_seq_i;
    assign d_old       = next_seq - 12'd1 - ackd_seq;
    assign next_seq_o  = next_seq;
    assign ackd_seq_o  = ackd_seq;
    assign fsm_state   = state;

    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        s_axis_tready = 1'b0;
        load_hdr      = 1'b0;
        load_beat     = 1'b0;
        force_trunc   = 1'b0;
        seq_inc       = 1'b0;
        case (state)
            IDLE: begin
                // Header load does not consume the input beat; it stays pending for PASS.
                if (s_axis_tvalid && !blocked_o && slot_free) begin
                    load_hdr      = 1'b1;
                    beat_cnt_next = '0;
                    state_next    = PASS;
                end
            end
            PASS: begin
                s_axis_tready = slot_free;
                if (s_axis_tvalid && slot_free) begin
                    load_beat     = 1'b1;
                    beat_cnt_next = beat_cnt + 1'b1;
                    if (s_axis_tlast) begin
                        seq_inc    = 1'b1;
                        state_next = IDLE;
                    end else if (beat_cnt == LAST_CNT) begin
                        force_trunc = 1'b1;
                        seq_inc     = 1'b1;
                        state_next  = DROP;
                    end
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        beat_user    = s_axis_tuser;
        beat_user[0] = s_axis_tuser[0] | force_trunc;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            beat_cnt <= '0;
            trunc_o  <= 1'b0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
            trunc_o  <= force_trunc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (load_hdr) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= DATA_WIDTH'({4'h0, next_seq, 16'h0});
            m_axis_tkeep  <= '1;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (load_beat) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast | force_trunc;
            m_axis_tuser  <= beat_user;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Sequence advances on input acceptance of the final beat; the ACK check uses the pre-increment value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            next_seq <= 12'h000;
            ackd_seq <= 12'hFFF;
        end else begin
            if (seq_inc) begin
                next_seq <= next_seq + 12'd1;
            end
            if (ack_valid_i && (d_new < d_old)) begin
                ackd_seq <= ack_seq_i;
            end
        end
    end

endmodule

// File: tb/tb_axis_tlp_seq_tagger.sv
// Randomized bench for axis_tlp_seq_tagger: frame-level reference model feeds an expected-beat queue,
// ACK window and blocking are modelled with plain modulo arithmetic.
module tb_axis_tlp_seq_tagger;

    localparam int MAXB = (256 >> 2) + 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic [3:0]  s_keep = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [0:0]  s_user = '0;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_last;
    logic [0:0]  m_user;
    logic        m_ready = 1'b1;
    logic        ack_valid = 1'b0;
    logic [11:0] ack_seq = '0;
    logic [11:0] next_seq;
    logic [11:0] ackd_seq;
    logic        blocked;
    logic        trunc;
    logic [1:0]  fsm_state;

    axis_tlp_seq_tagger dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tlast(s_last), .s_axis_tuser(s_user), .s_axis_tready(s_ready),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
        .m_axis_tlast(m_last), .m_axis_tuser(m_user), .m_axis_tready(m_ready),
        .ack_valid_i(ack_valid), .ack_seq_i(ack_seq),
        .next_seq_o(next_seq), .ackd_seq_o(ackd_seq),
        .blocked_o(blocked), .trunc_o(trunc), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          trunc_cnt = 0;
    bit          bp_en = 1'b0;
    logic [37:0] exp_q[$];
    logic [11:0] model_next = 12'h000;
    logic [11:0] model_ackd = 12'hFFF;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_blocked();
        logic [11:0] o;
        o = model_next - model_ackd - 12'd1;
        return o >= 12'd2048;
    endfunction

    // Output slot backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor and scoreboard
    bit          stall_prev = 1'b0;
    logic [37:0] prev_beat = '0;
    always @(negedge clk) begin
        logic [37:0] got;
        logic [37:0] e;
        got = {m_data, m_keep, m_last, m_user};
        if (rst_n) begin
            if (stall_prev) begin
                check_eq("hold_valid", m_valid, 1);
                check_eq("hold_beat", got, prev_beat);
            end
            if (m_valid && m_ready) begin
                check_eq("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("beat", got, e);
                end
            end
            if (trunc) trunc_cnt++;
            stall_prev = m_valid && !m_ready;
            prev_beat  = got;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        ack_valid = 1'b0;
        exp_q.delete();
        model_next = 12'h000;
        model_ackd = 12'hFFF;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_beat", {m_data, m_keep, m_last, m_user}, 0);
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_next_seq", next_seq, 12'h000);
        check_eq("rst_ackd_seq", ackd_seq, 12'hFFF);
        check_eq("rst_blocked", blocked, 0);
        check_eq("rst_trunc", trunc, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_ack(input logic [11:0] seq);
        logic [11:0] k;
        logic [11:0] o;
        ack_valid = 1'b1;
        ack_seq   = seq;
        @(posedge clk);
        #1;
        ack_valid = 1'b0;
        // accepted only if it lies strictly after ACKD_SEQ and not after NEXT_TRANSMIT_SEQ-1
        k = seq - model_ackd;
        o = model_next - model_ackd - 12'd1;
        if (k >= 12'd1 && k <= o) model_ackd = seq;
    endtask

    task automatic send_frame(input int len, input bit rnd);
        logic [31:0] d[$];
        logic [3:0]  kp[$];
        bit          u[$];
        bit          cut;
        bit          acc;
        int          n;
        for (int i = 0; i < len; i++) begin
            d.push_back(rnd ? $urandom : 32'hA0 + i);
            kp.push_back(rnd ? 4'($urandom_range(0, 15)) : 4'hF);
            u.push_back(rnd ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        cut = (len > MAXB);
        exp_q.push_back({4'h0, model_next, 16'h0, 4'hF, 1'b0, 1'b0});
        for (int i = 0; i < len && i < MAXB; i++) begin
            exp_q.push_back({d[i], kp[i], (i == len - 1) || (i == MAXB - 1),
                             u[i] | (cut && (i == MAXB - 1))});
        end
        model_next = model_next + 12'd1;
        for (int i = 0; i < len; i++) begin
            s_valid = 1'b1;
            s_data  = d[i];
            s_keep  = kp[i];
            s_user  = u[i];
            s_last  = (i == len - 1);
            n = 0;
            do begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!acc && n < 1000);
            if (!acc) begin
                check_eq("s_accept", acc, 1);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int t0;
        do_reset();

        // basic 3-beat frame then a second frame
        send_frame(3, 1'b0);
        wait_idle();
        check_eq("next_after_first", next_seq, model_next);
        send_frame(2, 1'b1);
        wait_idle();
        check_eq("next_after_second", next_seq, model_next);

        // randomized backpressure
        bp_en = 1'b1;
        repeat (20) send_frame($urandom_range(1, 6), 1'b1);
        wait_idle();
        check_eq("next_after_random", next_seq, model_next);

        // oversize frame truncation, followed by a normal frame
        t0 = trunc_cnt;
        send_frame(MAXB + 3, 1'b1);
        send_frame(2, 1'b1);
        wait_idle();
        bp_en = 1'b0;
        wait_idle();
        check_eq("trunc_pulses", trunc_cnt - t0, 1);
        check_eq("next_after_trunc", next_seq, model_next);

        // ACK ordering
        do_reset();
        repeat (8) send_frame(1, 1'b1);
        wait_idle();
        send_ack(12'd5);
        @(negedge clk);
        check_eq("ack_5", ackd_seq, model_ackd);
        @(posedge clk); #1;
        send_ack(12'd3);
        @(negedge clk);
        check_eq("ack_stale", ackd_seq, model_ackd);
        @(posedge clk); #1;
        send_ack(12'h800);
        @(negedge clk);
        check_eq("ack_range", ackd_seq, model_ackd);
        check_eq("ack_blocked", blocked, model_blocked());
        @(posedge clk); #1;

        // 2048 outstanding frames inhibit new headers
        do_reset();
        repeat (2048) send_frame(1, 1'b1);
        wait_idle();
        check_eq("blocked_2048", blocked, model_blocked());
        s_valid = 1'b1;
        s_data  = 32'h1234_5678;
        s_last  = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_eq("no_header_blocked", m_valid, 0);
        check_eq("still_blocked", blocked, model_blocked());
        @(posedge clk); #1;
        send_ack(12'h000);
        @(negedge clk);
        check_eq("ackd_unblock", ackd_seq, model_ackd);
        check_eq("unblocked", blocked, model_blocked());
        @(posedge clk); #1;
        send_frame(1, 1'b1);
        wait_idle();
        check_eq("next_resume", next_seq, model_next);

        // advance to 0xFFF with periodic ACKs, then cross the wrap
        send_ack(model_next - 12'd1);
        while (model_next != 12'hFFF) begin
            send_frame(1, 1'b1);
            if (model_next[7:0] == 8'h00) begin
                wait_idle();
                send_ack(model_next - 12'd1);
            end
        end
        wait_idle();
        send_ack(model_next - 12'd1);
        send_frame(2, 1'b1);
        send_frame(1, 1'b1);
        wait_idle();
        check_eq("next_wrapped", next_seq, model_next);
        send_ack(12'hFFF);
        @(negedge clk);
        check_eq("ack_fff_wrap", ackd_seq, model_ackd);
        @(posedge clk); #1;
        send_ack(12'h000);
        @(negedge clk);
        check_eq("ack_000_wrap", ackd_seq, model_ackd);
        check_eq("blocked_wrap", blocked, model_blocked());

        @(posedge clk); #1;
        check_eq("leftover", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/axis_tlp_seq_tagger.md
Name: axis_tlp_seq_tagger

Overview:
- Sits directly upstream of the data-link retry FIFO and stamps each outgoing TLP with its 12-bit data-link sequence number.
- Prepends one header beat per frame and tracks NEXT_TRANSMIT_SEQ and ACKD_SEQ.
- Stalls new frames while 2048 or more TLPs are outstanding, so the retry FIFO is never overrun.
- Truncates oversize frames so that no frame exceeds the retry FIFO slot size.

Parameters:
- DATA_WIDTH, 32, TLP data width; only 32 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 1, tuser width; bit 0 is the error flag.
- MAX_PAYLOAD_SIZE, 256, max payload bytes. MaxPktBeats = (MAX_PAYLOAD_SIZE>>2)+4, the input beat limit per frame.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  TLP input from the transaction layer.
- s_axis_tkeep  in  KEEP_WIDTH
- s_axis_tvalid  in  1
- s_axis_tlast  in  1
- s_axis_tuser  in  USER_WIDTH
- s_axis_tready  out  1
- m_axis_tdata  out  DATA_WIDTH  tagged TLP output to the retry FIFO.
- m_axis_tkeep  out  KEEP_WIDTH
- m_axis_tvalid  out  1
- m_axis_tlast  out  1
- m_axis_tuser  out  USER_WIDTH
- m_axis_tready  in  1
- ack_valid_i  in  1  ACK DLLP received, one-cycle pulse.
- ack_seq_i  in  12  AckNak_Seq_Num of that ACK.
- next_seq_o  out  12  NEXT_TRANSMIT_SEQ.
- ackd_seq_o  out  12  ACKD_SEQ.
- blocked_o  out  1  new frames are inhibited.
- trunc_o  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (async assert, sync deassert use):
  - FSM=IDLE.
  - m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tuser=0.
  - next_seq=0, ackd_seq=12'hFFF.
  - beat count=0, blocked_o=0, trunc_o=0, s_axis_tready=0.
- Output is a single registered stage. A beat is loaded when (!m_axis_tvalid || m_axis_tready). It is held stable while m_axis_tvalid && !m_axis_tready.
- outstanding = (next_seq - ackd_seq - 1) mod 4096.
- blocked_o = (outstanding >= 2048), combinational from registers.
- FSM:
  - IDLE: s_axis_tready=0. If s_axis_tvalid && !blocked_o && output slot free, load the header beat:
    - tdata={4'h0, next_seq, 16'h0}, tkeep all ones, tlast=0, tuser=0.
    - Go to PASS with beat count=0.
    - The input beat is not consumed in this cycle.
  - PASS: s_axis_tready = output slot free. Each accepted input beat is copied to the output registers unchanged; beat count increments.
    - On an accepted beat with s_axis_tlast: next_seq <= next_seq+1 (mod 4096); go to IDLE.
    - If the accepted beat is number MaxPktBeats (count reaches MaxPktBeats) without tlast: output tlast forced to 1, tuser[0] forced to 1; next_seq increments; trunc_o pulses; go to DROP.
  - DROP: s_axis_tready=1 and output is not loaded. Input beats are discarded until and including the beat with tlast, then go to IDLE.
- The sequence number increments on input acceptance of the final beat, not on output handshake. The header for frame N+1 is therefore never issued with a stale number.
- ACK handling: on ack_valid_i, compute d_new=(next_seq-1-ack_seq) mod 4096 and d_old=(next_seq-1-ackd_seq) mod 4096.
  - If d_new < d_old: ackd_seq <= ack_seq.
  - Otherwise ignore (stale or out of range; no error output).
- When an ACK and a sequence increment fall in the same cycle, both are applied. The ACK range check uses the pre-increment next_seq.
- Wrap: 12'hFFF+1 = 12'h000; all sequence arithmetic is modulo 4096.
- blocked_o is checked only in IDLE; a frame already in PASS always completes.
- Reset asserted mid-frame: all state clears immediately and the partial output frame is abandoned. Upstream must also be reset.
- Latency: header appears 1 cycle after s_axis_tvalid in IDLE. Each data beat appears 1 cycle after input acceptance. Throughput is 1 beat/cycle within a frame, plus one header bubble per frame.

Test Plan:
- 3-beat frame (0xA0,0xA1,0xA2, tlast on last) after reset, m_axis_tready=1 -> output is 0x00000000 header then 0xA0,0xA1,0xA2 with tlast on 0xA2; next_seq_o=1; second frame header = 0x00010000.
- Random m_axis_tready backpressure (50%) over 20 frames -> output beats equal expected stream exactly; no beat dropped or duplicated; tdata stable while stalled.
- 2048 frames with no ACK -> blocked_o=1 at outstanding=2048 and no new header is issued. Then ack_valid_i with ack_seq_i=0 -> ackd_seq_o=0, blocked_o=0, traffic resumes.
- ACK ordering: ack_seq 5, then 3 (stale), then 0x800 beyond next_seq-1 -> ackd_seq_o stays 5 after both invalid ACKs.
- Frame of MaxPktBeats+3=71 beats with MAX_PAYLOAD_SIZE=256 -> output is header + 68 beats with tlast and tuser[0]=1 on beat 68; trunc_o pulses once; remaining 3 input beats are consumed and discarded; next frame is tagged with the next sequence number.
- Seed next_seq to 0xFFF via 4095 frames with prompt ACKs -> header carries 0xFFF, then 0x000; ACK with ack_seq_i=0xFFF is accepted across the wrap.
